// File: rtl/silent_stepper.sv
// Time-multiplexed duty/phase slew limiter: one shared datapath visits one
// channel per cycle per UPDATE sweep, with an optional bypass copy mode.
module silent_stepper #(
  parameter int TRANS_NUM = 249,
  parameter int WIDTH     = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             UPDATE,
  input  logic             MODE,
  input  logic [WIDTH-1:0] STEP_DUTY,
  input  logic [WIDTH-1:0] STEP_PHASE,
  input  logic [WIDTH-1:0] DUTY   [0:TRANS_NUM-1],
  input  logic [WIDTH-1:0] PHASE  [0:TRANS_NUM-1],
  output logic [WIDTH-1:0] DUTYS  [0:TRANS_NUM-1],
  output logic [WIDTH-1:0] PHASES [0:TRANS_NUM-1],
  output logic             BUSY,
  output logic             DONE
);

  localparam int IDX_W = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TRANS_NUM - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic             pending, pending_nx;
  logic             mode_q, mode_nx;
  logic [WIDTH-1:0] sd_q, sd_nx, sp_q, sp_nx;
  logic             rdy;
  logic             wr_en, done_nx, start;

  logic [WIDTH-1:0] cur_d, tgt_d, duty_mag, duty_new;
  logic [WIDTH-1:0] cur_p, tgt_p, ph_d, ph_mag, phase_new;
  logic             duty_up, ph_neg;

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    pending_nx = pending;
    mode_nx    = mode_q;
    sd_nx      = sd_q;
    sp_nx      = sp_q;
    wr_en      = 1'b0;
    done_nx    = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (UPDATE && rdy) begin
          state_nx = SWEEP;
          idx_nx   = '0;
          start    = 1'b1;
        end
      end
      SWEEP: begin
        wr_en = 1'b1;
        if (idx == IDX_LAST) begin
          done_nx = 1'b1;
          idx_nx  = '0;
          // A strobe coinciding with the last write restarts without a gap
          if (pending || UPDATE) begin
            pending_nx = 1'b0;
            start      = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          idx_nx = idx + IDX_W'(1);
          if (UPDATE) pending_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (start) begin
      mode_nx = MODE;
      sd_nx   = STEP_DUTY;
      sp_nx   = STEP_PHASE;
    end
  end

  always_comb begin
    cur_d    = DUTYS[idx];
    tgt_d    = DUTY[idx];
    duty_up  = (tgt_d >= cur_d);
    duty_mag = duty_up ? (tgt_d - cur_d) : (cur_d - tgt_d);
    if (mode_q || (duty_mag <= sd_q)) duty_new = tgt_d;
    else if (duty_up)                 duty_new = cur_d + sd_q;
    else                              duty_new = cur_d - sd_q;

    // Half-circle distance counts as positive so ties step upward
    cur_p  = PHASES[idx];
    tgt_p  = PHASE[idx];
    ph_d   = tgt_p - cur_p;
    ph_neg = ph_d[WIDTH-1] && (ph_d[WIDTH-2:0] != '0);
    ph_mag = ph_neg ? ('0 - ph_d) : ph_d;
    if (mode_q || (ph_mag <= sp_q)) phase_new = tgt_p;
    else if (ph_neg)                phase_new = cur_p - sp_q;
    else                            phase_new = cur_p + sp_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= 1'b0;
      mode_q  <= 1'b0;
      sd_q    <= '0;
      sp_q    <= '0;
      rdy     <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      pending <= pending_nx;
      mode_q  <= mode_nx;
      sd_q    <= sd_nx;
      sp_q    <= sp_nx;
      rdy     <= 1'b1;
      BUSY    <= (state == SWEEP);
      DONE    <= done_nx;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < TRANS_NUM; i++) begin
        DUTYS[i]  <= '0;
        PHASES[i] <= '0;
      end
    end else if (wr_en) begin
      DUTYS[idx]  <= duty_new;
      PHASES[idx] <= phase_new;
    end
  end

endmodule

// File: tb/tb_silent_stepper.sv
// Directed bench for silent_stepper: latency, slewing, wrap, queueing, reset.
module tb_silent_stepper;

  localparam int TN = 249;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         update = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] step_duty = '0;
  logic [W-1:0] step_phase = '0;
  logic [W-1:0] duty   [0:TN-1];
  logic [W-1:0] phase  [0:TN-1];
  logic [W-1:0] dutys  [0:TN-1];
  logic [W-1:0] phases [0:TN-1];
  logic         busy, done;

  int checks = 0;
  int errors = 0;

  silent_stepper #(.TRANS_NUM(TN), .WIDTH(W)) dut (
    .CLK(clk), .RST_N(rst_n), .UPDATE(update), .MODE(mode),
    .STEP_DUTY(step_duty), .STEP_PHASE(step_phase),
    .DUTY(duty), .PHASE(phase), .DUTYS(dutys), .PHASES(phases),
    .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_targets(input int d, input int p);
    for (int i = 0; i < TN; i++) begin
      duty[i]  = W'(d);
      phase[i] = W'(p);
    end
  endtask

  // Strobe sampled at edge k; returns at the negedge following edge k
  task automatic pulse_update();
    @(negedge clk) update = 1'b1;
    @(negedge clk) update = 1'b0;
  endtask

  task automatic run_sweep();
    int seen;
    seen = 0;
    pulse_update();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("done_seen", seen, 1);
    @(negedge clk);
  endtask

  task automatic count_bad(output int bad, input int d, input int p);
    bad = 0;
    for (int i = 0; i < TN; i++)
      if (dutys[i] !== W'(d) || phases[i] !== W'(p)) bad++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, busy_cnt, done_cnt, last_done;
    set_targets(0, 0);
    repeat (3) @(negedge clk);
    chk("rst_dutys0", dutys[0], 0);
    chk("rst_phases0", phases[0], 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // UPDATE on the first edge after release must be ignored
    rst_n = 1'b1;
    update = 1'b1;
    @(negedge clk) update = 1'b0;
    @(negedge clk);
    chk("release_ignore", busy, 0);

    // First STEP sweep with latency checks
    mode = 1'b0; step_duty = 8'd16; step_phase = 8'd0;
    set_targets(200, 0);
    pulse_update();
    chk("lat_busy_k", busy, 0);
    @(negedge clk);
    chk("lat_busy_k1", busy, 1);
    chk("lat_ch0", dutys[0], 16);
    chk("lat_ch1_hold", dutys[1], 0);
    repeat (247) @(negedge clk);
    chk("lat_ch247", dutys[247], 16);
    chk("lat_ch248_hold", dutys[248], 0);
    chk("lat_done_early", done, 0);
    @(negedge clk);
    chk("lat_ch248", dutys[248], 16);
    chk("lat_done", done, 1);
    chk("lat_busy_last", busy, 1);
    @(negedge clk);
    chk("lat_done_off", done, 0);
    chk("lat_busy_off", busy, 0);
    count_bad(bad, 16, 0);
    chk("sweep1_all16", bad, 0);

    for (int s = 2; s <= 13; s++) begin
      run_sweep();
      if (s == 12) chk("sweep12_192", dutys[5], 192);
    end
    count_bad(bad, 200, 0);
    chk("sweep13_all200", bad, 0);
    run_sweep();
    chk("sweep14_hold", dutys[100], 200);

    // Bypass copy
    mode = 1'b1;
    set_targets(37, 99);
    run_sweep();
    count_bad(bad, 37, 99);
    chk("bypass_all", bad, 0);

    // Phase wrap with frozen duty
    set_targets(37, 250);
    run_sweep();
    mode = 1'b0; step_duty = 8'd0; step_phase = 8'd4;
    set_targets(200, 5);
    run_sweep();
    chk("wrap_254", phases[0], 254);
    chk("freeze_duty", dutys[0], 37);
    run_sweep();
    chk("wrap_2", phases[10], 2);
    run_sweep();
    chk("wrap_5", phases[248], 5);
    chk("freeze_duty2", dutys[7], 37);

    // Tie, negative wrap, duty decrement and snap
    mode = 1'b1;
    set_targets(37, 0);
    run_sweep();
    mode = 1'b0; step_duty = 8'd16; step_phase = 8'd1;
    phase[0] = 8'd128; phase[1] = 8'd129;
    duty[0] = 8'd10; duty[1] = 8'd30;
    run_sweep();
    chk("tie_plus", phases[0], 1);
    chk("neg_wrap", phases[1], 255);
    chk("duty_dec", dutys[0], 21);
    chk("duty_snap", dutys[1], 30);
    chk("duty_same", dutys[2], 37);

    // Three strobes during one sweep (last one on the final write) give two sweeps
    mode = 1'b1;
    set_targets(37, 99);
    busy_cnt = 0; done_cnt = 0; last_done = 0;
    pulse_update();
    for (int i = 1; i <= 600; i++) begin
      update = (i == 10 || i == 20 || i == 249);
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        last_done = i;
      end
    end
    update = 1'b0;
    chk("queue_busy", busy_cnt, 2 * TN);
    chk("queue_done", done_cnt, 2);
    chk("queue_last_done", last_done, 2 * TN);

    // Reset mid-sweep discards the queued request
    set_targets(60, 99);
    pulse_update();
    for (int i = 1; i <= 100; i++) begin
      update = (i == 50);
      @(negedge clk);
    end
    update = 1'b0;
    chk("mid_ch0", dutys[0], 60);
    chk("mid_unvisited", dutys[150], 37);
    rst_n = 1'b0;
    #1;
    chk("abort_duty", dutys[0], 0);
    chk("abort_phase", phases[150], 0);
    chk("abort_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_pending", busy, 0);
    chk("post_rst_duty", dutys[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
